// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding, word/byte-enable sizing and the byte-lane merge.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int BE_W       = 4;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] be_merge(input logic [31:0]     old_word,
                                           input logic [31:0]     new_word,
                                           input logic [BE_W-1:0] be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage for the data-memory responder.
// One byte-enable write port and one combinational read port on the same index.
// Contents are deliberately not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  input  logic [BE_W-1:0]  be,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write: untouched lanes keep their previous contents.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= be_merge(mem[idx], wdata, be);
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the MEM-stage load/store port.
// Accepts one request at a time on a valid/ready channel, waits WAIT_CYCLES
// cycles, performs the access on the edge that enters RESP and holds the
// response until it is taken.
// Optional build macro DMEM_MISALIGN_CHECK_EN: when defined, any access with
// addr[1:0] != 0 is reported as an error instead of being word-aligned.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  input  logic [BE_W-1:0] req_be,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err
);

  localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [29:0] DEPTH_30 = 30'(DEPTH_WORDS);

  state_t          state;
  logic [3:0]      cnt;
  logic            cap_we;
  logic [31:0]     cap_addr;
  logic [31:0]     cap_wdata;
  logic [BE_W-1:0] cap_be;

  logic            acc_we;
  logic [31:0]     acc_addr;
  logic [31:0]     acc_wdata;
  logic [BE_W-1:0] acc_be;
  logic            accept;
  logic            do_access;
  logic            range_err;
  logic            mis_err;
  logic            acc_err;
  logic            arr_we;
  logic [31:0]     arr_rdata;
  logic [31:0]     acc_rdata;

  assign accept = (state == IDLE) && req_valid && req_ready;

  // Access operands: live request when going straight to RESP, else the captured copy.
  always_comb begin
    acc_we    = cap_we;
    acc_addr  = cap_addr;
    acc_wdata = cap_wdata;
    acc_be    = cap_be;
    if (state == IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end
  end

  assign do_access = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd0));
  assign range_err = acc_addr[31:2] >= DEPTH_30;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign mis_err = |acc_addr[1:0];
`else
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^acc_addr[1:0];
  assign mis_err = 1'b0;
`endif

  assign acc_err   = range_err | mis_err;
  // Holding reset blocks the commit, so an aborted store never lands.
  assign arr_we    = do_access && acc_we && !acc_err && reset;
  assign acc_rdata = (acc_we || acc_err) ? 32'd0 : arr_rdata;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .idx   (acc_addr[IDX_W+1:2]),
    .wdata (acc_wdata),
    .be    (acc_be),
    .rdata (arr_rdata)
  );

  // Request/response FSM with wait counter, captured request and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      cnt       <= 4'd0;
      cap_we    <= 1'b0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      cap_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_we    <= req_we;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= acc_rdata;
              rsp_err   <= acc_err;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= acc_rdata;
            rsp_err   <= acc_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_rdata <= 32'd0;
          rsp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with WAIT_CYCLES=2 and one
// with WAIT_CYCLES=0 sharing the request fields, selected by `sel`.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rv = 1'b0;
  logic        rp = 1'b0;
  logic        sel = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_be = 4'd0;

  logic        req_valid_a, req_ready_a, rsp_ready_a, rsp_valid_a, rsp_err_a;
  logic [31:0] rsp_rdata_a;
  logic        req_valid_z, req_ready_z, rsp_ready_z, rsp_valid_z, rsp_err_z;
  logic [31:0] rsp_rdata_z;

  logic        cur_req_ready, cur_rsp_valid, cur_rsp_err;
  logic [31:0] cur_rsp_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;

  always #5 clk = ~clk;

  assign req_valid_a = rv && !sel;
  assign req_valid_z = rv && sel;
  assign rsp_ready_a = rp && !sel;
  assign rsp_ready_z = rp && sel;

  assign cur_req_ready = sel ? req_ready_z : req_ready_a;
  assign cur_rsp_valid = sel ? rsp_valid_z : rsp_valid_a;
  assign cur_rsp_err   = sel ? rsp_err_z   : rsp_err_a;
  assign cur_rsp_rdata = sel ? rsp_rdata_z : rsp_rdata_a;

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid_a),
    .req_ready (req_ready_a),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid_a),
    .rsp_ready (rsp_ready_a),
    .rsp_rdata (rsp_rdata_a),
    .rsp_err   (rsp_err_a)
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid_z),
    .req_ready (req_ready_z),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid_z),
    .rsp_ready (rsp_ready_z),
    .rsp_rdata (rsp_rdata_z),
    .rsp_err   (rsp_err_z)
  );

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // Entered just after a rising edge; returns just after the accept edge.
  task automatic accept(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    int n;
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    rv = 1'b1;
    n = 0;
    while (!cur_req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check32({"req_ready_wait@", $sformatf("%h", addr)}, 32'(cur_req_ready), 32'd1);
    @(posedge clk); #1;
    rv = 1'b0;
  endtask

  // Accept, then wait for rsp_valid; lat is accept-edge-to-rsp_valid in cycles.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output int l);
    int n;
    accept(we, addr, wdata, be);
    n = 0;
    while (!cur_rsp_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check32({"rsp_valid_wait@", $sformatf("%h", addr)}, 32'(cur_rsp_valid), 32'd1);
    l = n + 1;
  endtask

  task automatic take_rsp();
    rp = 1'b1;
    @(posedge clk); #1;
    rp = 1'b0;
  endtask

  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, output logic [31:0] r, output logic e, output int l);
    issue(we, addr, wdata, be, l);
    r = cur_rsp_rdata;
    e = cur_rsp_err;
    take_rsp();
  endtask

  initial begin
    // Reset state
    #2 reset = 1'b0;
    #8;
    check32("rst_req_ready", 32'(req_ready_a), 32'd1);
    check32("rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
    check32("rst_rsp_rdata", rsp_rdata_a, 32'd0);
    check32("rst_rsp_err",   32'(rsp_err_a), 32'd0);
    #12 reset = 1'b1;
    @(posedge clk); #1;

    // Store then load, latency 3
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    check32("st_latency", 32'(lat), 32'd3);
    check32("st_err", 32'(er), 32'd0);
    check32("st_rdata", rd, 32'd0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check32("ld_rdata", rd, 32'hDEADBEEF);
    check32("ld_err", 32'(er), 32'd0);
    check32("ld_latency", 32'(lat), 32'd3);

    // Byte-enable merge
    xact(1'b1, 32'h10, 32'h11223344, 4'b0101, rd, er, lat);
    xact(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    check32("be_merge", rd, 32'hDE22BE44);

    // Out of range
    xact(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, lat);
    xact(1'b0, 32'h100, 32'h0, 4'hF, rd, er, lat);
    check32("oor_ld_err", 32'(er), 32'd1);
    check32("oor_ld_rdata", rd, 32'd0);
    xact(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    check32("oor_st_err", 32'(er), 32'd1);
    xact(1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat);
    check32("oor_word0_kept", rd, 32'hCAFEF00D);

    // Store with no byte enables
    xact(1'b1, 32'h10, 32'h99999999, 4'h0, rd, er, lat);
    check32("be0_err", 32'(er), 32'd0);
    xact(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    check32("be0_nowrite", rd, 32'hDE22BE44);

    // Response backpressure
    issue(1'b0, 32'h10, 32'h0, 4'hF, lat);
    for (int i = 0; i < 5; i++) begin
      check32($sformatf("bp_valid_%0d", i), 32'(rsp_valid_a), 32'd1);
      check32($sformatf("bp_rdata_%0d", i), rsp_rdata_a, 32'hDE22BE44);
      check32($sformatf("bp_err_%0d", i), 32'(rsp_err_a), 32'd0);
      check32($sformatf("bp_req_ready_%0d", i), 32'(req_ready_a), 32'd0);
      @(posedge clk); #1;
    end
    take_rsp();
    check32("bp_after_req_ready", 32'(req_ready_a), 32'd1);
    check32("bp_after_rsp_valid", 32'(rsp_valid_a), 32'd0);

    // Reset during WAIT aborts a store
    xact(1'b1, 32'h20, 32'h12345678, 4'hF, rd, er, lat);
    accept(1'b1, 32'h20, 32'h55AA55AA, 4'hF);
    reset = 1'b0;
    #1;
    check32("abort_req_ready", 32'(req_ready_a), 32'd1);
    check32("abort_rsp_valid", 32'(rsp_valid_a), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    xact(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    check32("abort_no_commit", rd, 32'h12345678);

    // Misaligned load
    xact(1'b0, 32'h12, 32'h0, 4'hF, rd, er, lat);
`ifdef DMEM_MISALIGN_CHECK_EN
    check32("misalign_err", 32'(er), 32'd1);
    check32("misalign_rdata", rd, 32'd0);
`else
    check32("misalign_err", 32'(er), 32'd0);
    check32("misalign_rdata", rd, 32'hDE22BE44);
`endif

    // Zero wait-state instance
    sel = 1'b1;
    #1;
    xact(1'b1, 32'h4, 32'hA5A5A5A5, 4'hF, rd, er, lat);
    check32("w0_st_latency", 32'(lat), 32'd1);
    check32("w0_st_err", 32'(er), 32'd0);
    xact(1'b0, 32'h4, 32'h0, 4'hF, rd, er, lat);
    check32("w0_ld_latency", 32'(lat), 32'd1);
    check32("w0_ld_rdata", rd, 32'hA5A5A5A5);
    sel = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
